// File: rtl/upsampler.sv
// upsampler: rate expander emitting RATE = 2^LOG2_RATE outputs per accepted sample (zero-stuff, hold, linear).
module upsampler #(
    parameter int WIDTH     = 16,
    parameter int LOG2_RATE = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    output logic             underrun
);
    typedef enum logic {IDLE, RUN} state_t;

    state_t                 state, state_n;
    logic [LOG2_RATE-1:0]   phase, phase_n, phase_nx;
    logic [WIDTH-1:0]       prev, prev_n, cur, cur_n, out_n;
    logic [1:0]             mode_q, mode_n;
    logic                   valid_n, underrun_n, accept;

    // Linear term is floor((cur - prev) * k / RATE); it always lands between prev and cur.
    function automatic logic [WIDTH-1:0] expand(
        input logic [LOG2_RATE-1:0] k,
        input logic [WIDTH-1:0]     p,
        input logic [WIDTH-1:0]     c,
        input logic [1:0]           m
    );
        logic signed [WIDTH:0]           d;
        logic signed [WIDTH+LOG2_RATE:0] pr;
        d  = $signed({c[WIDTH-1], c}) - $signed({p[WIDTH-1], p});
        pr = $signed({{LOG2_RATE{d[WIDTH]}}, d}) * $signed({{(WIDTH+1){1'b0}}, k});
        pr = pr >>> LOG2_RATE;
        return m == 2'd0 ? (k == '0 ? c : '0) : m == 2'd2 ? p + pr[WIDTH-1:0] : c;
    endfunction

    assign in_ready = state == IDLE || &phase;
    assign accept   = in_valid && in_ready;
    assign phase_nx = phase + 1'b1;

    always_comb begin
        state_n    = state;
        phase_n    = phase;
        prev_n     = prev;
        cur_n      = cur;
        mode_n     = mode_q;
        out_n      = '0;
        valid_n    = 1'b0;
        underrun_n = 1'b0;
        if (accept) begin
            state_n = RUN;
            phase_n = '0;
            prev_n  = cur;
            cur_n   = in;
            mode_n  = mode;
            out_n   = expand('0, cur, in, mode);
            valid_n = 1'b1;
        end else if (state == RUN && &phase) begin
            state_n    = IDLE;
            phase_n    = '0;
            underrun_n = 1'b1;
        end else if (state == RUN) begin
            phase_n = phase_nx;
            out_n   = expand(phase_nx, prev, cur, mode_q);
            valid_n = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            phase     <= '0;
            prev      <= '0;
            cur       <= '0;
            mode_q    <= '0;
            out       <= '0;
            out_valid <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            state     <= state_n;
            phase     <= phase_n;
            prev      <= prev_n;
            cur       <= cur_n;
            mode_q    <= mode_n;
            out       <= out_n;
            out_valid <= valid_n;
            underrun  <= underrun_n;
        end
    end
endmodule

// File: tb/tb_upsampler.sv
// tb_upsampler: directed scoreboard bench for upsampler at RATE = 4.
module tb_upsampler;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] in = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  mode = '0;
    logic [15:0] out;
    logic        out_valid;
    logic        underrun;

    logic [15:0] q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          w;

    upsampler #(.WIDTH(16), .LOG2_RATE(2)) dut (
        .clk(clk), .reset(reset), .in(in), .in_valid(in_valid), .in_ready(in_ready),
        .mode(mode), .out(out), .out_valid(out_valid), .underrun(underrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Every valid output is matched against the oldest expected value.
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            if (q.size() == 0) chk("unexpected_out", {16'h0, out}, 32'hDEAD);
            else chk("out", {16'h0, out}, {16'h0, q.pop_front()});
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        in_valid = 1'b0;
        q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_out", {16'h0, out}, 32'h0);
        chk("rst_in_ready", {31'h0, in_ready}, 32'h1);
        chk("rst_underrun", {31'h0, underrun}, 32'h0);
    endtask

    task automatic send(input logic [15:0] v, input logic [1:0] m,
                        input logic [15:0] e0, input logic [15:0] e1,
                        input logic [15:0] e2, input logic [15:0] e3, output int waited);
        q.push_back(e0); q.push_back(e1); q.push_back(e2); q.push_back(e3);
        in = v;
        mode = m;
        in_valid = 1'b1;
        waited = 0;
        while (in_ready !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        chk("accept_ready", {31'h0, in_ready}, 32'h1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Called at the phase-0 cycle of the last sample; expects a clean underrun afterwards.
    task automatic drain_idle();
        repeat (3) @(negedge clk);
        @(negedge clk);
        chk("idle_out_valid", {31'h0, out_valid}, 32'h0);
        chk("idle_underrun", {31'h0, underrun}, 32'h1);
        chk("idle_in_ready", {31'h0, in_ready}, 32'h1);
        chk("idle_out", {16'h0, out}, 32'h0);
        chk("idle_queue_empty", q.size(), 32'h0);
        @(negedge clk);
        chk("underrun_one_cycle", {31'h0, underrun}, 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        // zero-stuff, back-to-back
        send(16'h1234, 2'd0, 16'h1234, 16'h0, 16'h0, 16'h0, w);
        send(16'h0100, 2'd0, 16'h0100, 16'h0, 16'h0, 16'h0, w);
        chk("zs_wait_phase3", w, 3);
        drain_idle();
        // hold
        send(16'hFFFB, 2'd1, 16'hFFFB, 16'hFFFB, 16'hFFFB, 16'hFFFB, w);
        send(16'h0007, 2'd1, 16'h0007, 16'h0007, 16'h0007, 16'h0007, w);
        chk("hold_ready_4th", w, 3);
        drain_idle();
        // linear from reset
        do_reset();
        send(16'd100, 2'd2, 16'h0000, 16'h0019, 16'h0032, 16'h004B, w);
        send(16'd200, 2'd2, 16'h0064, 16'h007D, 16'h0096, 16'h00AF, w);
        send(16'hFF9C, 2'd2, 16'h00C8, 16'h007D, 16'h0032, 16'hFFE7, w);
        send(16'd100, 2'd2, 16'hFF9C, 16'hFFCE, 16'h0000, 16'h0032, w);
        send(16'hFF9C, 2'd2, 16'h0064, 16'h0032, 16'h0000, 16'hFFCE, w);
        drain_idle();
        // resume after a gap: phase 0 is the pre-gap sample
        repeat (3) @(negedge clk);
        send(16'd300, 2'd2, 16'hFF9C, 16'h0000, 16'h0064, 16'h00C8, w);
        drain_idle();
        // reset during phase 2, together with a pending in_valid
        q.delete();
        send(16'h0555, 2'd1, 16'h0555, 16'h0555, 16'h0555, 16'h0555, w);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        in = 16'h7777;
        in_valid = 1'b1;
        @(negedge clk);
        q.delete();
        reset = 1'b0;
        in_valid = 1'b0;
        chk("midrst_out_valid", {31'h0, out_valid}, 32'h0);
        chk("midrst_out", {16'h0, out}, 32'h0);
        chk("midrst_in_ready", {31'h0, in_ready}, 32'h1);
        @(negedge clk);
        chk("rst_wins_no_accept", {31'h0, out_valid}, 32'h0);
        send(16'd40, 2'd2, 16'h0000, 16'h000A, 16'h0014, 16'h001E, w);
        drain_idle();
        // mode switch during phase 1 affects only the next sample
        send(16'd9, 2'd1, 16'h0009, 16'h0009, 16'h0009, 16'h0009, w);
        @(negedge clk);
        send(16'd11, 2'd0, 16'h000B, 16'h0000, 16'h0000, 16'h0000, w);
        chk("modesw_wait", w, 2);
        drain_idle();
        chk("final_queue_empty", q.size(), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/upsampler.md
# upsampler

Transmit-side rate expander: accepts 16-bit signed baseband samples at the symbol rate over a valid/ready handshake and emits one sample per clock at RATE = 2^LOG2_RATE times that rate. It is the transmit-chain counterpart to the receive-side decimator. It sits between the modulator/pulse-shaper output and the DAC/channel model. Three expansion modes are supported: zero-stuff, sample-hold and linear interpolation.

## Interface
- WIDTH, 16, sample width, two's complement
- LOG2_RATE, 2, log2 of expansion factor; RATE = 4 by default; legal 1..4
- clk  input  1  single clock; all logic on rising edge
- reset  input  1  synchronous, active-high
- in  input  WIDTH  input sample, signed
- in_valid  input  1  producer has a sample on in
- in_ready  output  1  block can accept a sample this cycle
- mode  input  2  0 = zero-stuff, 1 = hold, 2 = linear, 3 = reserved (treated as hold); sampled only on accept
- out  output  WIDTH  expanded sample, registered
- out_valid  output  1  out holds a valid sample this cycle
- underrun  output  1  one-cycle pulse: no input was available at a sample boundary

## Operation
- Accept: in_valid && in_ready on a rising edge. On accept: prev <= cur, cur <= in, mode_q <= mode, phase <= 0, state <= RUN.
- States:
  - IDLE: in_ready = 1, out_valid = 0, out = 0.
  - RUN: phase counts 0..RATE-1, with one output per cycle. in_ready = 1 only when phase == RATE-1.
- RUN at phase RATE-1:
  - If accept: continue seamlessly at phase 0 with the new sample.
  - Else: go to IDLE and pulse underrun on the next cycle.
- Output value at phase k (registered, so visible the cycle after phase k is computed):
  - zero-stuff: cur when k == 0, else 0. No gain compensation.
  - hold: cur for all k.
  - linear: prev + ((cur - prev) * k) >>> LOG2_RATE.
- Linear arithmetic rules:
  - Difference is computed in WIDTH+1 bits, product in WIDTH+1+LOG2_RATE bits.
  - Arithmetic shift floors toward minus infinity.
  - The result always lies between prev and cur, so no saturation is needed.
  - The result is truncated to WIDTH bits.
- prev/cur persistence: values are retained across IDLE. After an idle gap, linear mode interpolates from the last sample before the gap.
- mode changes take effect only at the next accept. mode_q is constant for a sample's RATE outputs.

## Timing
- Reset (synchronous) clears:
  - state to IDLE, phase to 0, prev/cur/out to 0
  - out_valid and underrun to 0; in_ready = 1 in the cycle after reset deasserts
- Reset mid-RUN: the next cycle is IDLE with out_valid = 0. All partially emitted samples are discarded.
- Latency, accept at edge t:
  - out_valid = 1 from cycle t+1.
  - Phase-0 value appears at t+1, phase-k value at t+1+k.
  - Linear mode inherently delays the signal by one input period: its phase-0 value is the previous sample.
- Throughput: one input per RATE cycles maximum. Back-to-back accepts at phase RATE-1 give continuous out_valid with no bubbles.
- in_valid held while in RUN with phase < RATE-1: not accepted, and the sample stays pending at the producer.
- underrun: asserted for exactly one cycle, the first IDLE cycle. It coincides with out_valid = 0.
- Simultaneous reset and in_valid: reset wins and nothing is accepted.

## Test plan
- Zero-stuff, RATE=4: accept 0x1234, then 0x0100 exactly at phase 3 → out = 0x1234,0,0,0,0x0100,0,0,0 with out_valid continuous for 8 cycles.
- Hold: accept -5 (0xFFFB), then 7 → out = -5 ×4 then 7 ×4. in_ready high only on the 4th cycle of each group.
- Linear, from reset:
  - Accept 100 → out = 0,25,50,75.
  - Then 200 → 100,125,150,175.
  - Then -100 → 200,125,50,-25.
  - Check floor behaviour with 100 → -100 giving 100,50,0,-50.
- Underrun: accept one sample, hold in_valid low → 4 valid outputs, then out_valid = 0, underrun = 1 for one cycle, in_ready = 1. Resume later in linear mode → phase-0 output equals the pre-gap sample.
- Reset mid-RUN at phase 2 → the next cycle has out_valid = 0, out = 0, in_ready = 1. A subsequent linear accept of 40 gives 0,10,20,30.
- Mode switch: change mode from 1 to 0 during phase 1 → the current sample continues in hold mode; the next accepted sample is zero-stuffed.
